// File: rtl/l1_dcache.sv
`default_nettype none
// ============================================================================
// Module   : l1_dcache
// Brief    : Direct-mapped, one-word-per-line, write-back/write-allocate L1
//            data cache with a simple request/ready interface to L2.
//            Optional hit/miss statistics are enabled by L1_DCACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module l1_dcache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  l2_read_req,
  output logic                  l2_write_req,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [DATA_WIDTH-1:0] l2_write_data,
  input  logic [DATA_WIDTH-1:0] l2_read_data,
  input  logic                  l2_read_ready,
  input  logic                  l2_write_ready,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int c_INDEX_W = $clog2(NUM_LINES);
  localparam int c_TAG_W   = ADDR_WIDTH - c_INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Line storage: valid/dirty need reset, tag/data do not.
  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [c_TAG_W-1:0]    tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES];

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  l2_rd_q, l2_rd_d;
  logic                  l2_wr_q, l2_wr_d;
  logic [ADDR_WIDTH-1:0] l2_addr_q, l2_addr_d;
  logic [DATA_WIDTH-1:0] l2_wdata_q, l2_wdata_d;

  logic                  w_line_we;
  logic [c_INDEX_W-1:0]  w_line_idx;
  logic [c_TAG_W-1:0]    w_line_tag;
  logic [DATA_WIDTH-1:0] w_line_data;
  logic                  w_line_dirty;

  logic [c_INDEX_W-1:0]  w_cpu_idx;
  logic [c_TAG_W-1:0]    w_cpu_tag;
  logic [c_INDEX_W-1:0]  w_req_idx;
  logic [c_TAG_W-1:0]    w_req_tag;
  logic                  w_accept;
  logic                  w_hit;
  logic                  w_victim_dirty;

  assign w_cpu_idx      = cpu_addr[c_INDEX_W-1:0];
  assign w_cpu_tag      = cpu_addr[ADDR_WIDTH-1:c_INDEX_W];
  assign w_req_idx      = addr_q[c_INDEX_W-1:0];
  assign w_req_tag      = addr_q[ADDR_WIDTH-1:c_INDEX_W];
  assign w_accept       = (state_q == ST_IDLE) && cpu_req_valid;
  assign w_hit          = valid_q[w_cpu_idx] && (tag_q[w_cpu_idx] == w_cpu_tag);
  assign w_victim_dirty = valid_q[w_cpu_idx] && dirty_q[w_cpu_idx];

  assign cpu_ready      = (state_q == ST_IDLE);
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_rdata      = rdata_q;
  assign l2_read_req    = l2_rd_q;
  assign l2_write_req   = l2_wr_q;
  assign l2_address     = l2_addr_q;
  assign l2_write_data  = l2_wdata_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    l2_rd_d      = l2_rd_q;
    l2_wr_d      = l2_wr_q;
    l2_addr_d    = l2_addr_q;
    l2_wdata_d   = l2_wdata_q;
    w_line_we    = 1'b0;
    w_line_idx   = w_req_idx;
    w_line_tag   = w_req_tag;
    w_line_data  = wdata_q;
    w_line_dirty = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req_valid) begin
          addr_d      = cpu_addr;
          we_d        = cpu_req_we;
          wdata_d     = cpu_wdata;
          w_line_idx  = w_cpu_idx;
          w_line_tag  = w_cpu_tag;
          w_line_data = cpu_wdata;
          if (w_hit) begin
            resp_valid_d = 1'b1;
            rdata_d      = cpu_req_we ? cpu_wdata : data_q[w_cpu_idx];
            w_line_we    = cpu_req_we;
            w_line_dirty = 1'b1;
          end else if (w_victim_dirty) begin
            state_d    = ST_WRITEBACK;
            l2_wr_d    = 1'b1;
            l2_addr_d  = {tag_q[w_cpu_idx], w_cpu_idx};
            l2_wdata_d = data_q[w_cpu_idx];
          end else if (cpu_req_we) begin
            // Write miss allocates the whole word; no refill needed.
            w_line_we    = 1'b1;
            w_line_dirty = 1'b1;
            resp_valid_d = 1'b1;
            rdata_d      = cpu_wdata;
          end else begin
            state_d   = ST_REFILL;
            l2_rd_d   = 1'b1;
            l2_addr_d = cpu_addr;
          end
        end
      end

      ST_WRITEBACK: begin
        if (l2_write_ready) begin
          l2_wr_d = 1'b0;
          if (we_q) begin
            w_line_we    = 1'b1;
            w_line_dirty = 1'b1;
            resp_valid_d = 1'b1;
            rdata_d      = wdata_q;
            state_d      = ST_IDLE;
          end else begin
            state_d   = ST_REFILL;
            l2_rd_d   = 1'b1;
            l2_addr_d = addr_q;
          end
        end
      end

      ST_REFILL: begin
        if (l2_read_ready) begin
          l2_rd_d      = 1'b0;
          w_line_we    = 1'b1;
          w_line_dirty = 1'b0;
          w_line_data  = l2_read_data;
          rdata_d      = l2_read_data;
          resp_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      l2_rd_q      <= 1'b0;
      l2_wr_q      <= 1'b0;
      l2_addr_q    <= '0;
      l2_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      l2_rd_q      <= l2_rd_d;
      l2_wr_q      <= l2_wr_d;
      l2_addr_q    <= l2_addr_d;
      l2_wdata_q   <= l2_wdata_d;
      if (w_line_we) begin
        valid_q[w_line_idx] <= 1'b1;
        dirty_q[w_line_idx] <= w_line_dirty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_line_we && !reset) begin
      tag_q[w_line_idx]  <= w_line_tag;
      data_q[w_line_idx] <= w_line_data;
    end
  end

`ifdef L1_DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (w_accept) begin
      if (w_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (!w_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l1_dcache.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_dcache
// Brief    : Scoreboard bench for l1_dcache with a latency-configurable L2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_dcache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic        cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        l2_read_req;
  logic        l2_write_req;
  logic [31:0] l2_address;
  logic [31:0] l2_write_data;
  logic [31:0] l2_read_data = '0;
  logic        l2_read_ready = 1'b0;
  logic        l2_write_ready = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  l1_dcache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LINES(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_we     (cpu_req_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_ready      (cpu_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_rdata      (cpu_rdata),
    .l2_read_req    (l2_read_req),
    .l2_write_req   (l2_write_req),
    .l2_address     (l2_address),
    .l2_write_data  (l2_write_data),
    .l2_read_data   (l2_read_data),
    .l2_read_ready  (l2_read_ready),
    .l2_write_ready (l2_write_ready),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } l2_txn_t;

  logic [31:0] sb_q[$];
  int unsigned resp_cycles[$];
  l2_txn_t     l2_log[$];
  int unsigned resp_cyc = 0;
  int unsigned acc_cyc  = 0;
  int          n_resp   = 0;

  // L2 model: grants ready after a programmable number of request cycles.
  int          rd_delay = 0, wr_delay = 0, rd_wait = 0, wr_wait = 0;
  logic [31:0] l2_rdata_cfg = '0;
  int          rd_req_cycles = 0, both_seen = 0;
  int unsigned rd_grant_cyc = 0;
  logic        rd_granted_prev = 1'b0;
  logic        rd_req_after_grant = 1'b0;

  always @(negedge clk) begin
    l2_read_ready  = 1'b0;
    l2_write_ready = 1'b0;
    if (rd_granted_prev) rd_req_after_grant = l2_read_req;
    rd_granted_prev = 1'b0;
    if (l2_read_req && l2_write_req) both_seen++;
    if (reset) begin
      rd_wait = 0;
      wr_wait = 0;
    end else begin
      if (l2_read_req) begin
        rd_req_cycles++;
        if (rd_wait >= rd_delay) begin
          l2_read_ready = 1'b1;
          l2_read_data  = l2_rdata_cfg;
          l2_log.push_back('{1'b0, l2_address, l2_rdata_cfg});
          rd_grant_cyc    = cyc;
          rd_granted_prev = 1'b1;
          rd_wait = 0;
        end else begin
          rd_wait++;
        end
      end else begin
        rd_wait = 0;
      end
      if (l2_write_req) begin
        if (wr_wait >= wr_delay) begin
          l2_write_ready = 1'b1;
          l2_log.push_back('{1'b1, l2_address, l2_write_data});
          wr_wait = 0;
        end else begin
          wr_wait++;
        end
      end else begin
        wr_wait = 0;
      end
    end
  end

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && cpu_resp_valid) begin
      resp_cyc = cyc;
      resp_cycles.push_back(cyc);
      n_resp++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: cpu_resp_valid with rdata %h, required no response", cpu_rdata);
      end else begin
        logic [31:0] exp;
        exp = sb_q.pop_front();
        if (cpu_rdata !== exp) begin
          n_fail++;
          $display("FAIL resp_data: got %h, required %h", cpu_rdata, exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp);
    int guard = 0;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_addr      = addr;
    cpu_wdata     = wd;
    while (!cpu_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cpu_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: cpu_ready %b, required 1", cpu_ready);
      cpu_req_valid = 1'b0;
      return;
    end
    sb_q.push_back(exp);
    acc_cyc = cyc;
    @(negedge clk);
    cpu_req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks += 9;
    if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", cpu_ready); end
    if (cpu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b, required 0", cpu_resp_valid); end
    if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h, required 0", cpu_rdata); end
    if (l2_read_req !== 1'b0) begin n_fail++; $display("FAIL rst_l2_rd: got %b, required 0", l2_read_req); end
    if (l2_write_req !== 1'b0) begin n_fail++; $display("FAIL rst_l2_wr: got %b, required 0", l2_write_req); end
    if (l2_address !== 32'h0) begin n_fail++; $display("FAIL rst_l2_addr: got %h, required 0", l2_address); end
    if (l2_write_data !== 32'h0) begin n_fail++; $display("FAIL rst_l2_wdata: got %h, required 0", l2_write_data); end
    if (hit_count !== 32'h0) begin n_fail++; $display("FAIL rst_hits: got %0d, required 0", hit_count); end
    if (miss_count !== 32'h0) begin n_fail++; $display("FAIL rst_misses: got %0d, required 0", miss_count); end
  endtask

  task automatic test_read_miss_hit();
    int rd0;
    rd_delay = 3;
    l2_rdata_cfg = 32'hCAFE0001;
    l2_log.delete();
    cpu_access(1'b0, 32'h10, 32'h0, 32'hCAFE0001);
    wait_done();
    n_checks += 3;
    if (l2_log.size() != 1) begin
      n_fail++;
      $display("FAIL miss_l2_count: got %0d L2 transactions, required 1", l2_log.size());
    end else if (l2_log[0].wr !== 1'b0 || l2_log[0].addr !== 32'h10) begin
      n_fail++;
      $display("FAIL miss_l2_req: got wr=%b addr=%h, required wr=0 addr=00000010", l2_log[0].wr, l2_log[0].addr);
    end
    if (resp_cyc != rd_grant_cyc + 1) begin
      n_fail++;
      $display("FAIL miss_latency: resp at %0d, required %0d", resp_cyc, rd_grant_cyc + 1);
    end
    if (rd_req_cycles == 0) begin
      n_fail++;
      $display("FAIL miss_rd_req: got %0d request cycles, required >0", rd_req_cycles);
    end
    rd0 = rd_req_cycles;
    l2_log.delete();
    cpu_access(1'b0, 32'h10, 32'h0, 32'hCAFE0001);
    wait_done();
    n_checks += 2;
    if (resp_cyc != acc_cyc + 1) begin
      n_fail++;
      $display("FAIL hit_latency: resp at %0d, required %0d", resp_cyc, acc_cyc + 1);
    end
    if (rd_req_cycles != rd0 || l2_log.size() != 0) begin
      n_fail++;
      $display("FAIL hit_no_l2: got %0d L2 transactions, required 0", l2_log.size());
    end
  endtask

  task automatic test_writeback();
    rd_delay = 2;
    wr_delay = 1;
    l2_log.delete();
    cpu_access(1'b1, 32'h05, 32'h11111111, 32'h11111111);
    wait_done();
    n_checks++;
    if (l2_log.size() != 0) begin
      n_fail++;
      $display("FAIL wmiss_no_l2: got %0d L2 transactions, required 0", l2_log.size());
    end
    l2_rdata_cfg = 32'hBEEF0045;
    cpu_access(1'b0, 32'h45, 32'h0, 32'hBEEF0045);
    wait_done();
    n_checks++;
    if (l2_log.size() != 2) begin
      n_fail++;
      $display("FAIL wb_count: got %0d L2 transactions, required 2", l2_log.size());
    end else if (l2_log[0].wr !== 1'b1 || l2_log[0].addr !== 32'h05 || l2_log[0].data !== 32'h11111111 ||
                 l2_log[1].wr !== 1'b0 || l2_log[1].addr !== 32'h45) begin
      n_fail++;
      $display("FAIL wb_order: got [wr=%b %h %h][wr=%b %h], required [wr=1 00000005 11111111][wr=0 00000045]",
               l2_log[0].wr, l2_log[0].addr, l2_log[0].data, l2_log[1].wr, l2_log[1].addr);
    end
  endtask

  task automatic test_back_to_back();
    int   rd0;
    logic ready_all;
    rd_delay = 0;
    for (int i = 1; i <= 4; i++) begin
      l2_rdata_cfg = 32'hA0000000 + i;
      cpu_access(1'b0, i, 32'h0, 32'hA0000000 + i);
      wait_done();
    end
    resp_cycles.delete();
    rd0 = rd_req_cycles;
    ready_all = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cpu_req_valid = 1'b1;
      cpu_req_we    = 1'b0;
      cpu_addr      = i;
      if (cpu_ready !== 1'b1) ready_all = 1'b0;
      sb_q.push_back(32'hA0000000 + i);
      @(negedge clk);
    end
    cpu_req_valid = 1'b0;
    wait_done();
    n_checks += 3;
    if (ready_all !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got ready dropped, required held 1");
    end
    if (resp_cycles.size() != 4 || resp_cycles[3] - resp_cycles[0] != 3) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d responses, required 4 in consecutive cycles", resp_cycles.size());
    end
    if (rd_req_cycles != rd0) begin
      n_fail++;
      $display("FAIL b2b_no_l2: got %0d extra read cycles, required 0", rd_req_cycles - rd0);
    end
  endtask

  task automatic test_fast_refill();
    int rd0;
    rd_delay = 0;
    l2_rdata_cfg = 32'h5A5A5A5A;
    rd0 = rd_req_cycles;
    cpu_access(1'b0, 32'h20, 32'h0, 32'h5A5A5A5A);
    wait_done();
    n_checks += 3;
    if (rd_req_after_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL fast_deassert: l2_read_req %b after ready, required 0", rd_req_after_grant);
    end
    if (resp_cyc != rd_grant_cyc + 1) begin
      n_fail++;
      $display("FAIL fast_latency: resp at %0d, required %0d", resp_cyc, rd_grant_cyc + 1);
    end
    if (rd_req_cycles - rd0 != 1) begin
      n_fail++;
      $display("FAIL fast_req_cycles: got %0d, required 1", rd_req_cycles - rd0);
    end
  endtask

  task automatic test_reset_mid_refill();
    int n0;
    rd_delay = 20;
    l2_rdata_cfg = 32'hDEAD0030;
    n0 = n_resp;
    cpu_access(1'b0, 32'h30, 32'h0, 32'hDEAD0030);
    repeat (3) @(negedge clk);
    n_checks++;
    if (l2_read_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_refill_req: got %b, required 1", l2_read_req);
    end
    reset = 1'b1;
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    n_checks += 2;
    if (n_resp != n0) begin
      n_fail++;
      $display("FAIL abort_no_resp: got %0d responses, required 0", n_resp - n0);
    end
    if (cpu_ready !== 1'b1 || l2_read_req !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: ready=%b rd_req=%b, required 1 0", cpu_ready, l2_read_req);
    end
    rd_delay = 1;
    l2_rdata_cfg = 32'h12340010;
    l2_log.delete();
    cpu_access(1'b0, 32'h10, 32'h0, 32'h12340010);
    wait_done();
    n_checks++;
    if (l2_log.size() != 1 || l2_log[0].addr !== 32'h10) begin
      n_fail++;
      $display("FAIL post_reset_miss: got %0d L2 transactions, required 1 read of 00000010", l2_log.size());
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_hits, exp_miss;
`ifdef L1_DCACHE_STATS_EN
    exp_hits = 32'd3;
    exp_miss = 32'd2;
`else
    exp_hits = 32'd0;
    exp_miss = 32'd0;
`endif
    apply_reset();
    rd_delay = 1;
    l2_rdata_cfg = 32'h00000A10;
    cpu_access(1'b0, 32'h10, 32'h0, 32'h00000A10);
    wait_done();
    cpu_access(1'b1, 32'h10, 32'h00000077, 32'h00000077);
    wait_done();
    cpu_access(1'b0, 32'h10, 32'h0, 32'h00000077);
    wait_done();
    l2_rdata_cfg = 32'h00000A11;
    cpu_access(1'b0, 32'h11, 32'h0, 32'h00000A11);
    wait_done();
    cpu_access(1'b0, 32'h11, 32'h0, 32'h00000A11);
    wait_done();
    n_checks += 2;
    if (hit_count !== exp_hits) begin
      n_fail++;
      $display("FAIL stats_hits: got %0d, required %0d", hit_count, exp_hits);
    end
    if (miss_count !== exp_miss) begin
      n_fail++;
      $display("FAIL stats_misses: got %0d, required %0d", miss_count, exp_miss);
    end
  endtask

  task automatic test_l2_exclusive();
    n_checks++;
    if (both_seen != 0) begin
      n_fail++;
      $display("FAIL l2_exclusive: both requests high in %0d cycles, required 0", both_seen);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_writeback();
    test_back_to_back();
    test_fast_refill();
    test_reset_mid_refill();
    test_stats();
    test_l2_exclusive();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l1_dcache.md
L1_DCACHE -- requirements
Module: l1_dcache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter NUM_LINES, default 64, power of two, direct-mapped line count; one word per line.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cpu_req_valid  input  1  CPU request present.
REQ-007 SHALL have port cpu_req_we  input  1  1=write, 0=read.
REQ-008 SHALL have port cpu_addr  input  ADDR_WIDTH  request word address.
REQ-009 SHALL have port cpu_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port cpu_ready  output  1  request accepted when cpu_req_valid&&cpu_ready.
REQ-011 SHALL have port cpu_resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port cpu_rdata  output  DATA_WIDTH  read data; for writes, the written word.
REQ-013 SHALL have ports l2_read_req / l2_write_req  output  1 each  requests to the L2 cache.
REQ-014 SHALL have ports l2_address  output  ADDR_WIDTH  and l2_write_data  output  DATA_WIDTH.
REQ-015 SHALL have ports l2_read_data  input  DATA_WIDTH, l2_read_ready  input  1, l2_write_ready  input  1.
REQ-016 SHALL have ports hit_count, miss_count  output  32 each  statistics (see Configuration).

Function
REQ-017 SHALL split address: index = cpu_addr[log2(NUM_LINES)-1:0], tag = remaining upper bits; each line holds valid, dirty, tag, data.
REQ-018 SHALL implement FSM states IDLE, WRITEBACK, REFILL; cpu_ready = (state==IDLE), combinational.
REQ-019 SHALL, on a hit accepted in cycle N, pulse cpu_resp_valid at N+1 and stay IDLE, so back-to-back hits sustain one per cycle.
REQ-020 SHALL, on a write hit, store cpu_wdata and set dirty=1.
REQ-021 SHALL, on a miss accepted at N whose victim is valid and dirty, enter WRITEBACK at N+1: l2_write_req=1, l2_address={victim tag, index}, l2_write_data=victim data.
REQ-022 SHALL, on a read miss with clean or invalid victim (or after WRITEBACK), enter REFILL: l2_read_req=1, l2_address=request address.
REQ-023 SHALL hold l2 request, address and data stable until the matching ready is sampled high, deasserting the request in the following cycle; ready arriving in the first request cycle is accepted.
REQ-024 SHALL, when l2_read_ready is sampled in REFILL at cycle M, install the line (valid=1, dirty=0, new tag, l2_read_data), drive cpu_rdata=l2_read_data with cpu_resp_valid at M+1, and be IDLE at M+1.
REQ-025 SHALL treat a write miss as whole-line write with no refill: after any writeback, install line valid=1, dirty=1, data=cpu_wdata, with cpu_resp_valid one cycle after install decision.
REQ-026 SHALL latch request address, we and wdata at acceptance; CPU inputs are ignored outside IDLE.
REQ-027 SHALL ignore l2_read_ready / l2_write_ready when the matching request is not asserted.
REQ-028 SHALL never assert l2_read_req and l2_write_req in the same cycle.

Reset
REQ-029 SHALL, on reset, clear all valid and dirty bits, enter IDLE, and drive cpu_resp_valid=0, cpu_rdata=0, l2_read_req=0, l2_write_req=0, l2_address=0, l2_write_data=0, hit_count=0, miss_count=0.
REQ-030 SHALL, on reset mid-WRITEBACK or mid-REFILL, abandon the transaction (dirty data discarded) and produce no cpu_resp_valid.

Configuration
REQ-031 SHALL compile hit/miss counters only when macro L1_DCACHE_STATS_EN is defined: each accepted hit increments hit_count and each accepted miss increments miss_count, both saturating at 0xFFFFFFFF.
REQ-032 SHALL, without L1_DCACHE_STATS_EN, keep ports hit_count and miss_count present and tied to 0, with no counter logic.

Verification
REQ-033 SHALL verify: after reset, read 0x10 with L2 returning 0xCAFE0001 after 3 cycles -> one l2_read_req at addr 0x10, cpu_rdata=0xCAFE0001, then re-read 0x10 -> hit, resp next cycle, no L2 traffic.
REQ-034 SHALL verify: write 0x05=0x11111111 (miss), then read 0x45 (same index, NUM_LINES=64) -> l2_write_req addr 0x05 data 0x11111111 precedes l2_read_req addr 0x45.
REQ-035 SHALL verify: four back-to-back read hits to 0x01..0x04 -> cpu_ready held 1, four consecutive cpu_resp_valid pulses.
REQ-036 SHALL verify: l2_read_ready=1 in first REFILL cycle -> request deasserted next cycle, response one cycle after ready.
REQ-037 SHALL verify: reset asserted mid-REFILL -> no response, all lines invalid; subsequent read 0x10 misses.
REQ-038 SHALL verify: with L1_DCACHE_STATS_EN, 2 misses and 3 hits -> miss_count=2, hit_count=3; without, both read 0.
